// File: rtl/wb_lsu_master_v2.sv
// Wishbone classic master for a load/store unit: one outstanding access, lane steering,
// load sign/zero extension, alignment checking and a bus-cycle timeout.
module wb_lsu_master_v2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    output logic [ADDR_WIDTH-1:0]   o_ADDR,
    output logic [DATA_WIDTH-1:0]   o_DATA,
    input  logic [DATA_WIDTH-1:0]   i_DATA,
    output logic                    o_WE,
    output logic [DATA_WIDTH/8-1:0] o_SEL,
    output logic                    o_STB,
    output logic                    o_CYC,
    input  logic                    i_ACK,
    input  logic                    i_ERR,
    input  logic                    i_LSU_REQ,
    input  logic [ADDR_WIDTH-1:0]   i_LSU_ADDR,
    input  logic [DATA_WIDTH-1:0]   i_LSU_DATA,
    input  logic                    i_LSU_WE,
    input  logic [1:0]              i_LSU_HB,
    input  logic                    i_LSU_UNSIGNED,
    output logic                    o_LSU_RDY,
    output logic                    o_LSU_VALID,
    output logic [DATA_WIDTH-1:0]   o_LSU_DATA,
    output logic                    o_LSU_ERR,
    output logic [1:0]              o_LSU_ERR_CODE
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(SEL_W);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [1:0]         hb_q;
    logic               uns_q;
    logic [OFS_W-1:0]   ofs_q;

    logic [SEL_W-1:0]      lane_mask;
    logic [SEL_W-1:0]      sel_nx;
    logic [2:0]            align_mask;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic                  illegal;
    logic                  timeout;

    // Right-aligns the addressed lanes and extends them to the full bus width.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] rd,
        input logic [OFS_W-1:0]      ofs,
        input logic [1:0]            hb,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        logic signed [7:0]     sb;
        logic signed [15:0]    sw16;
        logic signed [31:0]    sw32;
        logic [DATA_WIDTH-1:0] r;
        sh   = rd >> {ofs, 3'b000};
        sb   = sh[7:0];
        sw16 = sh[15:0];
        sw32 = sh[31:0];
        case (hb)
            2'b00: begin
                if (uns) r = DATA_WIDTH'(sh[7:0]);
                else     r = DATA_WIDTH'(sb);
            end
            2'b01: begin
                if (uns) r = DATA_WIDTH'(sh[15:0]);
                else     r = DATA_WIDTH'(sw16);
            end
            2'b10: begin
                if (uns) r = DATA_WIDTH'(sh[31:0]);
                else     r = DATA_WIDTH'(sw32);
            end
            default: r = sh;
        endcase
        return r;
    endfunction

    always_comb begin
        lane_mask  = '1;
        align_mask = 3'b111;
        wdata_rep  = i_LSU_DATA;
        case (i_LSU_HB)
            2'b00: begin
                lane_mask  = SEL_W'(1);
                align_mask = 3'b000;
                wdata_rep  = {SEL_W{i_LSU_DATA[7:0]}};
            end
            2'b01: begin
                lane_mask  = SEL_W'(3);
                align_mask = 3'b001;
                wdata_rep  = {(SEL_W/2){i_LSU_DATA[15:0]}};
            end
            2'b10: begin
                lane_mask  = SEL_W'(15);
                align_mask = 3'b011;
                wdata_rep  = {(SEL_W/4){i_LSU_DATA[31:0]}};
            end
            default: ;
        endcase
        sel_nx  = lane_mask << i_LSU_ADDR[OFS_W-1:0];
        illegal = (|(i_LSU_ADDR[2:0] & align_mask)) ||
                  ((i_LSU_HB == 2'b11) && (DATA_WIDTH == 32));
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge i_CLK) begin
        if (i_RST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_LSU_REQ) state_nx = illegal ? RESP : BUS;
            BUS:     if (i_ACK || i_ERR || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_LSU_RDY   = (state == IDLE) && !i_RST;
    assign o_LSU_VALID = (state == RESP);

    // Bus drive and response capture; the response registers hold between transactions.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_ADDR         <= '0;
            o_DATA         <= '0;
            o_WE           <= 1'b0;
            o_SEL          <= '0;
            o_STB          <= 1'b0;
            o_CYC          <= 1'b0;
            o_LSU_DATA     <= '0;
            o_LSU_ERR      <= 1'b0;
            o_LSU_ERR_CODE <= 2'b00;
            cnt            <= '0;
            we_q           <= 1'b0;
            hb_q           <= 2'b00;
            uns_q          <= 1'b0;
            ofs_q          <= '0;
        end else begin
            case (state)
                IDLE: if (i_LSU_REQ) begin
                    we_q  <= i_LSU_WE;
                    hb_q  <= i_LSU_HB;
                    uns_q <= i_LSU_UNSIGNED;
                    ofs_q <= i_LSU_ADDR[OFS_W-1:0];
                    cnt   <= '0;
                    if (illegal) begin
                        o_LSU_DATA     <= '0;
                        o_LSU_ERR      <= 1'b1;
                        o_LSU_ERR_CODE <= 2'b01;
                    end else begin
                        o_CYC  <= 1'b1;
                        o_STB  <= 1'b1;
                        o_WE   <= i_LSU_WE;
                        o_SEL  <= sel_nx;
                        o_ADDR <= {i_LSU_ADDR[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
                        o_DATA <= wdata_rep;
                    end
                end
                BUS: begin
                    if (i_ACK || i_ERR || timeout) begin
                        o_CYC      <= 1'b0;
                        o_STB      <= 1'b0;
                        o_WE       <= 1'b0;
                        o_SEL      <= '0;
                        o_ADDR     <= '0;
                        o_DATA     <= '0;
                        o_LSU_DATA <= '0;
                        o_LSU_ERR  <= 1'b1;
                        if (i_ERR) begin
                            o_LSU_ERR_CODE <= 2'b10;
                        end else if (i_ACK) begin
                            o_LSU_ERR      <= 1'b0;
                            o_LSU_ERR_CODE <= 2'b00;
                            if (!we_q) o_LSU_DATA <= extend_load(i_DATA, ofs_q, hb_q, uns_q);
                        end else begin
                            o_LSU_ERR_CODE <= 2'b11;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master_v2.sv
// Randomized bench for wb_lsu_master_v2: a 32-bit and a 64-bit instance share stimulus and
// are checked against a byte-level reference model of the access rules.
module tb_wb_lsu_master_v2;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req32, req64;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_data, bus_rdata;
    logic        lsu_we, lsu_uns, ack, err;
    logic [1:0]  lsu_hb;
    bit          use64;

    logic [31:0] a32, d32, ld32;
    logic [3:0]  sel32;
    logic        we32, stb32, cyc32, rdy32, vld32, er32;
    logic [1:0]  ec32;
    logic [31:0] a64;
    logic [63:0] d64, ld64;
    logic [7:0]  sel64;
    logic        we64, stb64, cyc64, rdy64, vld64, er64;
    logic [1:0]  ec64;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] last_sel, last_adr, last_odata, last_we, last_ld, last_code;
    int          last_cycles;

    always #5 clk = ~clk;

    wb_lsu_master_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut32 (
        .i_CLK(clk), .i_RST(rst), .o_ADDR(a32), .o_DATA(d32), .i_DATA(bus_rdata[31:0]),
        .o_WE(we32), .o_SEL(sel32), .o_STB(stb32), .o_CYC(cyc32), .i_ACK(ack), .i_ERR(err),
        .i_LSU_REQ(req32), .i_LSU_ADDR(lsu_addr), .i_LSU_DATA(lsu_data[31:0]), .i_LSU_WE(lsu_we),
        .i_LSU_HB(lsu_hb), .i_LSU_UNSIGNED(lsu_uns), .o_LSU_RDY(rdy32), .o_LSU_VALID(vld32),
        .o_LSU_DATA(ld32), .o_LSU_ERR(er32), .o_LSU_ERR_CODE(ec32)
    );

    wb_lsu_master_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(TO)) dut64 (
        .i_CLK(clk), .i_RST(rst), .o_ADDR(a64), .o_DATA(d64), .i_DATA(bus_rdata),
        .o_WE(we64), .o_SEL(sel64), .o_STB(stb64), .o_CYC(cyc64), .i_ACK(ack), .i_ERR(err),
        .i_LSU_REQ(req64), .i_LSU_ADDR(lsu_addr), .i_LSU_DATA(lsu_data), .i_LSU_WE(lsu_we),
        .i_LSU_HB(lsu_hb), .i_LSU_UNSIGNED(lsu_uns), .o_LSU_RDY(rdy64), .o_LSU_VALID(vld64),
        .o_LSU_DATA(ld64), .o_LSU_ERR(er64), .o_LSU_ERR_CODE(ec64)
    );

    logic [63:0] o_dat, o_ld;
    logic [31:0] o_adr;
    logic [7:0]  o_sel;
    logic        o_we, o_stb, o_cyc, o_rdy, o_vld, o_er, other_vld, other_cyc;
    logic [1:0]  o_ec;

    assign o_dat     = use64 ? d64 : {32'b0, d32};
    assign o_ld      = use64 ? ld64 : {32'b0, ld32};
    assign o_adr     = use64 ? a64 : a32;
    assign o_sel     = use64 ? sel64 : {4'b0, sel32};
    assign o_we      = use64 ? we64 : we32;
    assign o_stb     = use64 ? stb64 : stb32;
    assign o_cyc     = use64 ? cyc64 : cyc32;
    assign o_rdy     = use64 ? rdy64 : rdy32;
    assign o_vld     = use64 ? vld64 : vld32;
    assign o_er      = use64 ? er64 : er32;
    assign o_ec      = use64 ? ec64 : ec32;
    assign other_vld = use64 ? vld32 : vld64;
    assign other_cyc = use64 ? cyc32 : cyc64;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write data: byte lane i carries byte (i mod access-size) of the store data.
    function automatic logic [63:0] m_wdata(input int dw, input int nb, input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < dw / 8; i++)
            r = r | (((d >> ((i % nb) * 8)) & 64'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [63:0] m_load(input int dw, input int nb, input int ofs,
                                           input bit uns, input logic [63:0] rd_in);
        logic [63:0] rd, raw, mask, v;
        rd   = (dw == 32) ? (rd_in & 64'hFFFF_FFFF) : rd_in;
        raw  = rd >> (8 * ofs);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = raw & mask;
        if (!uns && raw[8 * nb - 1]) v = v | ~mask;
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // kind: 0 ACK, 1 ERR, 2 ACK+ERR, 3 silent slave. dly: BUS cycles before the reply.
    task automatic run_txn(input bit w, input logic [31:0] addr, input logic [1:0] hb,
                           input bit we, input bit uns, input logic [63:0] wd,
                           input logic [63:0] rd, input int kind, input int dly);
        int          dw, nb, ofs, cycles, guard, exp_cyc;
        bit          ill;
        logic [63:0] exp_ld;
        logic [1:0]  exp_code;
        dw  = w ? 64 : 32;
        nb  = 1 << hb;
        ofs = int'(addr) % (dw / 8);
        ill = (int'(addr) % nb != 0) || (dw == 32 && hb == 2'b11);
        if (ill)            exp_code = 2'b01;
        else if (kind == 3) exp_code = 2'b11;
        else if (kind == 0) exp_code = 2'b00;
        else                exp_code = 2'b10;
        exp_ld  = (!ill && kind == 0 && !we) ? m_load(dw, nb, ofs, uns, rd) : 64'd0;
        exp_cyc = (kind == 3) ? TO + 1 : dly + 1;

        use64 = w;
        #0;
        check("rdy_idle", 64'(o_rdy), 64'd1);
        lsu_addr = addr; lsu_hb = hb; lsu_we = we; lsu_uns = uns; lsu_data = wd;
        bus_rdata = {$urandom, $urandom};
        if (w) req64 = 1'b1; else req32 = 1'b1;
        @(posedge clk); #1;
        req32 = 1'b0; req64 = 1'b0;
        lsu_addr = $urandom; lsu_data = {$urandom, $urandom};
        lsu_we = 1'($urandom); lsu_hb = 2'($urandom); lsu_uns = 1'($urandom);
        last_cycles = 0;
        if (ill) begin
            check("ill_cyc", 64'(o_cyc), 64'd0);
        end else begin
            check("stb", 64'(o_stb), 64'd1);
            check("rdy_busy", 64'(o_rdy), 64'd0);
            check("adr", 64'(o_adr), 64'(addr - 32'(ofs)));
            check("sel", 64'(o_sel), 64'(((1 << nb) - 1) << ofs));
            check("we", 64'(o_we), 64'(we));
            check("odata", o_dat, m_wdata(dw, nb, wd));
            last_sel = 64'(o_sel); last_adr = 64'(o_adr);
            last_odata = o_dat; last_we = 64'(o_we);
            if ($urandom_range(0, 1) == 1) begin
                if (w) req64 = 1'b1; else req32 = 1'b1;
            end
            cycles = 0;
            guard  = 0;
            while (o_cyc === 1'b1 && guard < 64) begin
                cycles++;
                if (kind != 3 && cycles - 1 == dly) begin
                    bus_rdata = rd;
                    ack = (kind == 0 || kind == 2);
                    err = (kind == 1 || kind == 2);
                end
                @(posedge clk); #1;
                ack = 1'b0; err = 1'b0;
                bus_rdata = {$urandom, $urandom};
                guard++;
            end
            req32 = 1'b0; req64 = 1'b0;
            last_cycles = cycles;
            check("cyc_len", 64'(cycles), 64'(exp_cyc));
            check("cyc_drop", 64'(o_cyc) | 64'(o_stb) | 64'(o_we), 64'd0);
            check("bus_clear", 64'(o_sel) | 64'(o_adr) | o_dat, 64'd0);
        end
        check("vld", 64'(o_vld), 64'd1);
        check("code", 64'(o_ec), 64'(exp_code));
        check("err", 64'(o_er), 64'(exp_code != 2'b00));
        check("ldata", o_ld, exp_ld);
        last_ld = o_ld; last_code = 64'(o_ec);
        @(posedge clk); #1;
        check("vld_pulse", 64'(o_vld), 64'd0);
        check("code_hold", 64'(o_ec), 64'(exp_code));
        check("ldata_hold", o_ld, exp_ld);
        check("other_quiet", 64'(other_vld) | 64'(other_cyc), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req32 = 1'b0; req64 = 1'b0; ack = 1'b0; err = 1'b0;
        lsu_addr = '0; lsu_data = '0; lsu_we = 1'b0; lsu_uns = 1'b0; lsu_hb = 2'b00;
        bus_rdata = '0; use64 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl32", {58'b0, rdy32, vld32, cyc32, stb32, we32, er32}, 64'd0);
        check("rst_data32", 64'(a32) | 64'(d32) | 64'(ld32) | 64'(sel32) | 64'(ec32), 64'd0);
        check("rst_ctrl64", {58'b0, rdy64, vld64, cyc64, stb64, we64, er64}, 64'd0);
        check("rst_data64", 64'(a64) | d64 | ld64 | 64'(sel64) | 64'(ec64), 64'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", {62'b0, rdy32, rdy64}, 64'd3);

        run_txn(1'b0, 32'h103, 2'b00, 1'b0, 1'b0, 64'h0, 64'h80FF_FF00, 0, 0);
        check("lb_sel", last_sel, 64'h8);
        check("lb_adr", last_adr, 64'h100);
        check("lb_data", last_ld, 64'hFFFF_FF80);

        run_txn(1'b0, 32'h202, 2'b01, 1'b1, 1'b0, 64'h1234, 64'h0, 0, 1);
        check("sh_sel", last_sel, 64'hC);
        check("sh_odata", last_odata, 64'h1234_1234);
        check("sh_we", last_we, 64'd1);
        check("sh_ldata", last_ld, 64'd0);

        run_txn(1'b0, 32'h101, 2'b10, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0);
        check("mis_code", last_code, 64'd1);

        run_txn(1'b0, 32'h40, 2'b10, 1'b0, 1'b0, 64'h0, 64'h0, 3, 0);
        check("to_len", 64'(last_cycles), 64'(TO + 1));
        check("to_code", last_code, 64'd3);
        run_txn(1'b0, 32'h44, 2'b10, 1'b0, 1'b0, 64'h0, 64'h0, 2, 2);
        check("ackerr_code", last_code, 64'd2);

        ack = 1'b1; err = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; err = 1'b0;
        @(posedge clk); #1;
        check("stray_ack", {60'b0, vld32, vld64, cyc32, cyc64}, 64'd0);

        run_txn(1'b1, 32'h10, 2'b11, 1'b0, 1'b0, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 1);
        check("ld_sel", last_sel, 64'hFF);
        check("ld_data", last_ld, 64'h8123_4567_89AB_CDEF);

        use64 = 1'b1;
        lsu_addr = 32'h08; lsu_hb = 2'b11; lsu_we = 1'b0; lsu_uns = 1'b0;
        req64 = 1'b1;
        @(posedge clk); #1;
        req64 = 1'b0;
        check("rb_sel", 64'(sel64), 64'hFF);
        check("rb_cyc", 64'(cyc64), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rb_drop", {61'b0, cyc64, stb64, vld64}, 64'd0);
        rst = 1'b0;
        #1;
        check("rb_rdy", 64'(rdy64), 64'd1);
        @(posedge clk); #1;
        check("rb_novld", 64'(vld64), 64'd0);

        for (int t = 0; t < 60; t++) begin
            bit          w;
            logic [1:0]  hb;
            logic [31:0] addr;
            int          r, kind;
            w    = 1'($urandom);
            hb   = 2'($urandom);
            addr = $urandom & 32'hFFFF;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << hb) - 32'd1);
            r    = $urandom_range(0, 7);
            kind = (r < 5) ? 0 : (r - 4);
            run_txn(w, addr, hb, 1'($urandom), 1'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, kind, $urandom_range(0, TO));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
